// File: rtl/cory_pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM encodings and state type.
package cory_pulse_stretch_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] HIGH_ENC = 2'd1;
  localparam logic [1:0] GAP_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_HIGH = HIGH_ENC,
    ST_GAP  = GAP_ENC
  } ps_state_t;

endpackage

// File: rtl/cory_pulse_stretch_sat.sv
// Saturating up/down counter; simultaneous inc and dec cancel, inc at full drops.
module cory_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         ovf
);

  assign full = (cnt == {W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      case ({inc, dec})
        2'b10: begin
          if (full) ovf <= 1'b1;
          else      cnt <= cnt + W'(1);
        end
        2'b01: if (cnt != '0) cnt <= cnt - W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cory_pulse_stretch.sv
// Pulse stretcher: each request yields a max(i_len,1)-cycle high pulse, separated
// by i_gap low cycles; requests arriving while busy are queued in a saturating counter.
module cory_pulse_stretch
  import cory_pulse_stretch_pkg::*;
#(
  parameter int CW     = 8,
  parameter int PW     = 4,
  parameter int RETRIG = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a,
  input  logic [CW-1:0] i_len,
  input  logic [CW-1:0] i_gap,
  output logic          o_z,
  output logic          o_busy,
  output logic [PW-1:0] o_pend,
  output logic          o_ovf
);

  ps_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_ld;
  logic          last;
  logic          retrig_hit;
  logic          req_q;
  logic          have_next;
  logic          hi_end;
  logic          gp_end;
  logic          pend_dec;

  assign len_ld     = (i_len == '0) ? CW'(1) : i_len;
  assign last       = (cnt == CW'(1));
  assign retrig_hit = (RETRIG != 0) && (state == ST_HIGH) && i_a;
  // A request landing on the consume cycle counts toward have_next so it is
  // served back-to-back with a net-zero pending change.
  assign req_q      = i_a && (state != ST_IDLE) && !retrig_hit;
  assign have_next  = (o_pend != '0) || req_q;

  always_comb begin
    hi_end   = (state == ST_HIGH) && last && !retrig_hit;
    gp_end   = (state == ST_GAP) && last;
    pend_dec = have_next && ((hi_end && (i_gap == '0)) || gp_end);
  end

  cory_sat_cnt #(.W(PW)) u_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (req_q),
    .dec     (pend_dec),
    .cnt     (o_pend),
    .full    (),
    .ovf     (o_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      o_z   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_a) begin
            state <= ST_HIGH;
            cnt   <= len_ld;
            o_z   <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (retrig_hit) begin
            cnt <= len_ld;
          end else if (!last) begin
            cnt <= cnt - CW'(1);
          end else if (i_gap != '0) begin
            state <= ST_GAP;
            cnt   <= i_gap;
            o_z   <= 1'b0;
          end else if (have_next) begin
            cnt <= len_ld;
          end else begin
            state <= ST_IDLE;
            cnt   <= '0;
            o_z   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (!last) begin
            cnt <= cnt - CW'(1);
          end else if (have_next) begin
            state <= ST_HIGH;
            cnt   <= len_ld;
            o_z   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          o_z   <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE) || (o_pend != '0);

endmodule

// File: doc/cory_pulse_stretch.md
CORY_PULSE_STRETCH -- requirements
Module: cory_pulse_stretch

Interface
REQ-001 SHALL have parameter CW, 8, width of length/gap counters.
REQ-002 SHALL have parameter PW, 4, width of pending-request counter.
REQ-003 SHALL have parameter RETRIG, 0, 1 = request during high phase reloads length instead of queuing.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_a  input  1  one-shot request; every cycle sampled high = one request.
REQ-007 SHALL have port i_len  input  CW  high-phase length in cycles; 0 treated as 1.
REQ-008 SHALL have port i_gap  input  CW  forced low cycles between consecutive output pulses; 0 allowed.
REQ-009 SHALL have port o_z  output  1  stretched pulse, registered.
REQ-010 SHALL have port o_busy  output  1  high when state != IDLE or pending != 0.
REQ-011 SHALL have port o_pend  output  PW  queued requests not yet started.
REQ-012 SHALL have port o_ovf  output  1  one-cycle pulse when a request is dropped.

Function
REQ-013 SHALL implement FSM IDLE, HIGH, GAP; o_z = 1 exactly in HIGH.
REQ-014 IDLE + i_a=1 SHALL go to HIGH next cycle (latency 1), loading length counter with max(i_len,1).
REQ-015 HIGH SHALL last exactly max(i_len,1) cycles, i_len sampled only at HIGH entry.
REQ-016 HIGH end SHALL go to GAP if i_gap sampled at that cycle > 0, else HIGH if pending > 0 (pending-1, back-to-back, o_z stays 1), else IDLE.
REQ-017 GAP SHALL last exactly i_gap cycles, then HIGH if pending > 0 (pending-1) else IDLE.
REQ-018 i_a in HIGH with RETRIG=0 SHALL increment pending; with RETRIG=1 SHALL reload length counter to max(i_len,1) and leave pending unchanged.
REQ-019 i_a in GAP SHALL increment pending regardless of RETRIG.
REQ-020 i_a on the same cycle pending is consumed SHALL leave pending unchanged (net zero).
REQ-021 Pending SHALL saturate at 2^PW-1; request arriving at full (and not offset by a consume) SHALL be dropped and o_ovf pulse 1 cycle.
REQ-022 Counters SHALL count down, no wrap; length/gap value 2^CW-1 SHALL be valid.
REQ-023 i_a in IDLE SHALL never increment pending.

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, o_z=0, o_busy=0, o_pend=0, o_ovf=0, counters 0.
REQ-025 Reset mid-HIGH or mid-GAP SHALL abort the pulse immediately and discard all pending requests.
REQ-026 First request after reset release SHALL behave as from IDLE.

Structure
REQ-027 FSM state encodings (IDLE=0, HIGH=1, GAP=2, 2 bits) SHALL live in the shared cory package/include as localparams.
REQ-028 Pending counter SHALL be a sub-module cory_sat_cnt (saturating up/down, inc/dec/full/ovf ports, width PW).
REQ-029 Top SHALL contain FSM, length/gap counter and output registers only.

Verification
REQ-030 Single request: i_len=3, i_gap=0, i_a pulse at cycle 0 -> o_z high cycles 1-3, o_busy low cycle 4.
REQ-031 i_len=0 -> o_z high exactly 1 cycle.
REQ-032 Queue: RETRIG=0, i_len=2, i_gap=2, i_a at cycles 0,1,2 -> o_z high 1-2, 5-6, 9-10; o_pend peaks 2.
REQ-033 Retrigger: RETRIG=1, i_len=4, i_a at cycles 0 and 3 -> o_z high cycles 1-7, o_pend stays 0.
REQ-034 Overflow: PW=2, i_len=10, 5 requests during HIGH -> o_pend=3, o_ovf pulses twice.
REQ-035 Reset mid-HIGH with o_pend=2 -> o_z=0, o_pend=0 asynchronously; no pulse after release.
